// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues data-memory requests, stalls the front end while an access
// is outstanding, and hands results to MEM/WB. Define MEM_TIMEOUT_EN to enable the access timeout.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        valid_IN,
  input  logic [31:0] Next_Instruct_IN,
  input  logic [31:0] operator2_IN,
  input  logic [31:0] Result_ULA_Jump_IN,
  input  logic [31:0] Result_ULA_Operator_IN,
  input  logic        Flag_ULA_IN,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic        Branch_IN,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        PC_Src_OUT,
  output logic [31:0] Branch_Target_OUT,
  output logic        valid_OUT,
  output logic [31:0] Read_Data_OUT,
  output logic [31:0] Result_ULA_Operator_OUT,
  output logic [31:0] Next_Instruct_OUT,
  output logic        mem_error
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, pc4_q, result_q, br_target_q, read_data_q;
  logic        we_q, valid_out_q, pc_src_q;
  logic        mem_op, accept_mem, in_access, timeout;

  assign mem_op     = MemRead_IN | MemWrite_IN;
  assign accept_mem = (state_q == StIdle) & valid_IN & mem_op;
  assign in_access  = (state_q == StAccess);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            mem_error_q;

  // cnt_q holds the number of ACCESS cycles already spent; an ack in the last one still wins.
  assign timeout = in_access & ~mem_ack & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_q       <= '0;
      mem_error_q <= 1'b0;
    end else begin
      cnt_q       <= in_access ? cnt_q + 1'b1 : '0;
      mem_error_q <= timeout;
    end
  end

  assign mem_error = mem_error_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign mem_error          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept_mem) state_d = StAccess;
      StAccess: if (mem_ack || timeout) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      pc4_q       <= '0;
      result_q    <= '0;
      br_target_q <= '0;
      read_data_q <= '0;
      valid_out_q <= 1'b0;
      pc_src_q    <= 1'b0;
    end else begin
      valid_out_q <= 1'b0;
      pc_src_q    <= 1'b0;
      // Only IDLE acceptance evaluates an instruction, so a stalled one is never seen twice.
      if (state_q == StIdle && valid_IN) begin
        pc4_q       <= Next_Instruct_IN;
        result_q    <= Result_ULA_Operator_IN;
        br_target_q <= Result_ULA_Jump_IN;
        pc_src_q    <= Branch_IN & Flag_ULA_IN;
        if (mem_op) begin
          addr_q  <= {Result_ULA_Operator_IN[31:2], 2'b00};
          wdata_q <= operator2_IN;
          we_q    <= MemWrite_IN;
        end else begin
          read_data_q <= '0;
          valid_out_q <= 1'b1;
        end
      end
      if (in_access && (mem_ack || timeout)) begin
        read_data_q <= (mem_ack && !we_q) ? mem_rdata : '0;
        valid_out_q <= 1'b1;
      end
    end
  end

  assign mem_req                 = in_access;
  assign mem_we                  = in_access & we_q;
  assign mem_addr                = addr_q;
  assign mem_wdata               = wdata_q;
  // Gated by clear so the front end is released the moment reset is asserted.
  assign stall                   = clear & (accept_mem | in_access);
  assign PC_Src_OUT              = pc_src_q;
  assign Branch_Target_OUT       = br_target_q;
  assign valid_OUT               = valid_out_q;
  assign Read_Data_OUT           = read_data_q;
  assign Result_ULA_Operator_OUT = result_q;
  assign Next_Instruct_OUT       = pc4_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a randomized pipeline run
// against a transaction-level model of the stage.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        clear;
  logic        valid_IN;
  logic [31:0] Next_Instruct_IN, operator2_IN, Result_ULA_Jump_IN, Result_ULA_Operator_IN;
  logic        Flag_ULA_IN, MemRead_IN, MemWrite_IN, Branch_IN;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        stall, PC_Src_OUT, valid_OUT, mem_error;
  logic [31:0] Branch_Target_OUT, Read_Data_OUT, Result_ULA_Operator_OUT, Next_Instruct_OUT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clock                   (clock),
    .clear                   (clear),
    .valid_IN                (valid_IN),
    .Next_Instruct_IN        (Next_Instruct_IN),
    .operator2_IN            (operator2_IN),
    .Result_ULA_Jump_IN      (Result_ULA_Jump_IN),
    .Result_ULA_Operator_IN  (Result_ULA_Operator_IN),
    .Flag_ULA_IN             (Flag_ULA_IN),
    .MemRead_IN              (MemRead_IN),
    .MemWrite_IN             (MemWrite_IN),
    .Branch_IN               (Branch_IN),
    .mem_req                 (mem_req),
    .mem_we                  (mem_we),
    .mem_addr                (mem_addr),
    .mem_wdata               (mem_wdata),
    .mem_rdata               (mem_rdata),
    .mem_ack                 (mem_ack),
    .stall                   (stall),
    .PC_Src_OUT              (PC_Src_OUT),
    .Branch_Target_OUT       (Branch_Target_OUT),
    .valid_OUT               (valid_OUT),
    .Read_Data_OUT           (Read_Data_OUT),
    .Result_ULA_Operator_OUT (Result_ULA_Operator_OUT),
    .Next_Instruct_OUT       (Next_Instruct_OUT),
    .mem_error               (mem_error)
  );

  typedef struct {
    logic        valid, rd, wr, br, fl;
    logic [31:0] res, op2, jmp, pc4, rdata;
    int          lat;
  } instr_t;

  typedef struct {
    logic [31:0] rdata, res, pc4;
  } exp_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    valid_IN = 0; MemRead_IN = 0; MemWrite_IN = 0; Branch_IN = 0; Flag_ULA_IN = 0;
    mem_ack = 0;
    Next_Instruct_IN = '0; operator2_IN = '0; Result_ULA_Jump_IN = '0; Result_ULA_Operator_IN = '0;
  endtask

  task automatic set_instr(input logic rd, input logic wr, input logic br, input logic fl,
                           input logic [31:0] res, input logic [31:0] op2,
                           input logic [31:0] jmp, input logic [31:0] pc4);
    valid_IN = 1; MemRead_IN = rd; MemWrite_IN = wr; Branch_IN = br; Flag_ULA_IN = fl;
    Result_ULA_Operator_IN = res; operator2_IN = op2; Result_ULA_Jump_IN = jmp;
    Next_Instruct_IN = pc4;
  endtask

  task automatic test_reset();
    clear = 0;
    set_idle();
    mem_rdata = '0;
    #3;
    n_checks++;
    if ({mem_req, mem_we, stall, PC_Src_OUT, valid_OUT, mem_error} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 000000",
               {mem_req, mem_we, stall, PC_Src_OUT, valid_OUT, mem_error});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, Branch_Target_OUT, Read_Data_OUT, Result_ULA_Operator_OUT,
         Next_Instruct_OUT} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got nonzero 32-bit output want all zero");
    end
    @(posedge clock);
    @(posedge clock);
    #1 clear = 1;
  endtask

  task automatic test_load();
    int stall_cnt = 0;
    mem_rdata = 32'hDEAD_BEEF;
    set_instr(1, 0, 0, 0, 32'h0000_0103, 32'hAAAA_5555, 32'h0, 32'h0000_0014);
    #1;
    if (stall === 1'b1) stall_cnt++;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (stall === 1'b1) stall_cnt++;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0100 || mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL load_access cycle %0d got req=%b addr=%h we=%b want 1 00000100 0",
                 c, mem_req, mem_addr, mem_we);
      end
      if (c == 3) mem_ack = 1;
    end
    tick();
    mem_ack = 0;
    #1;
    if (stall === 1'b1) stall_cnt++;
    n_checks++;
    if (valid_OUT !== 1'b1 || Read_Data_OUT !== 32'hDEAD_BEEF || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done got valid=%b data=%h req=%b want 1 deadbeef 0",
               valid_OUT, Read_Data_OUT, mem_req);
    end
    n_checks++;
    if (Next_Instruct_OUT !== 32'h14 || Result_ULA_Operator_OUT !== 32'h103) begin
      n_fail++;
      $display("FAIL load_fwd got pc4=%h res=%h want 14 103", Next_Instruct_OUT,
               Result_ULA_Operator_OUT);
    end
    n_checks++;
    if (stall_cnt != 4) begin
      n_fail++;
      $display("FAIL load_stall_cycles got %0d want 4", stall_cnt);
    end
    set_idle();
    tick();
    n_checks++;
    if (valid_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL load_single_pulse got valid=%b want 0", valid_OUT);
    end
  endtask

  task automatic test_store();
    mem_rdata = 32'hFFFF_FFFF;
    set_instr(0, 1, 0, 0, 32'h0000_0040, 32'h1234_5678, 32'h0, 32'h0000_0020);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL store_accept_stall got %b want 1", stall);
    end
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678 ||
        mem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL store_access got req=%b we=%b wdata=%h addr=%h want 1 1 12345678 40",
               mem_req, mem_we, mem_wdata, mem_addr);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    n_checks++;
    if (valid_OUT !== 1'b1 || Read_Data_OUT !== 32'h0) begin
      n_fail++;
      $display("FAIL store_done got valid=%b data=%h want 1 0", valid_OUT, Read_Data_OUT);
    end
    set_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    int stall_seen = 0;
    for (int i = 0; i < 3; i++) begin
      set_instr(0, 0, 0, 0, 32'(5 + i), 32'h0, 32'h0, 32'(32'h100 + 4 * i));
      mem_ack = 1;  // stray ack outside ACCESS must be ignored
      #1;
      if (stall !== 1'b0) stall_seen++;
      tick();
      n_checks++;
      if (valid_OUT !== 1'b1 || Result_ULA_Operator_OUT !== 32'(5 + i) ||
          Read_Data_OUT !== 32'h0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_op%0d got valid=%b res=%h rd=%h req=%b want 1 %h 0 0", i,
                 valid_OUT, Result_ULA_Operator_OUT, Read_Data_OUT, mem_req, 32'(5 + i));
      end
    end
    n_checks++;
    if (stall_seen != 0) begin
      n_fail++;
      $display("FAIL b2b_stall got %0d stalled cycles want 0", stall_seen);
    end
    set_idle();
    tick();
    n_checks++;
    if (valid_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_valid got %b want 0", valid_OUT);
    end
  endtask

  task automatic test_branch();
    set_instr(0, 0, 1, 1, 32'h0, 32'h0, 32'h0000_0080, 32'h0);
    tick();
    n_checks++;
    if (PC_Src_OUT !== 1'b1 || Branch_Target_OUT !== 32'h80) begin
      n_fail++;
      $display("FAIL branch_taken got src=%b tgt=%h want 1 80", PC_Src_OUT, Branch_Target_OUT);
    end
    set_idle();
    tick();
    n_checks++;
    if (PC_Src_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_pulse got src=%b want 0", PC_Src_OUT);
    end
    set_instr(0, 0, 1, 0, 32'h0, 32'h0, 32'h0000_0200, 32'h0);
    tick();
    n_checks++;
    if (PC_Src_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_not_taken got src=%b want 0", PC_Src_OUT);
    end
    set_idle();
    tick();
  endtask

  task automatic test_clear_mid_access();
    set_instr(1, 0, 0, 0, 32'h0000_0200, 32'h0, 32'h0, 32'h0);
    mem_rdata = 32'h5555_AAAA;
    tick();
    tick();
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_pre_req got %b want 1", mem_req);
    end
    #2 clear = 0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || valid_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_immediate got req=%b stall=%b valid=%b want 0 0 0",
               mem_req, stall, valid_OUT);
    end
    mem_ack = 1;
    tick();
    n_checks++;
    if (valid_OUT !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_held got valid=%b req=%b want 0 0", valid_OUT, mem_req);
    end
    @(negedge clock);
    set_idle();
    set_instr(0, 0, 0, 0, 32'h0000_0099, 32'h0, 32'h0, 32'h0000_0044);
    clear = 1;
    tick();
    n_checks++;
    if (valid_OUT !== 1'b1 || Result_ULA_Operator_OUT !== 32'h99 || Read_Data_OUT !== 32'h0) begin
      n_fail++;
      $display("FAIL clear_first_accept got valid=%b res=%h rd=%h want 1 99 0",
               valid_OUT, Result_ULA_Operator_OUT, Read_Data_OUT);
    end
    set_idle();
    tick();
  endtask

  task automatic test_timeout();
    int acc = 0;
    set_instr(1, 0, 0, 0, 32'h0000_0300, 32'h0, 32'h0, 32'h0);
    mem_rdata = 32'h0BAD_0BAD;
    tick();
`ifdef MEM_TIMEOUT_EN
    while (mem_req === 1'b1 && acc < 64) begin
      acc++;
      tick();
    end
    n_checks++;
    if (acc != 16 || mem_error !== 1'b1 || valid_OUT !== 1'b1 || Read_Data_OUT !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout got cycles=%0d err=%b valid=%b rd=%h want 16 1 1 0",
               acc, mem_error, valid_OUT, Read_Data_OUT);
    end
    set_idle();
    tick();
    n_checks++;
    if (mem_error !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_after got err=%b req=%b want 0 0", mem_error, mem_req);
    end
    set_instr(1, 0, 0, 0, 32'h0000_0304, 32'h0, 32'h0, 32'h0);
    mem_rdata = 32'hCAFE_F00D;
    tick();
    for (int c = 1; c < 16; c++) tick();
    mem_ack = 1;
    tick();
    mem_ack = 0;
    n_checks++;
    if (mem_error !== 1'b0 || valid_OUT !== 1'b1 || Read_Data_OUT !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL ack_wins got err=%b valid=%b rd=%h want 0 1 cafef00d",
               mem_error, valid_OUT, Read_Data_OUT);
    end
`else
    for (int c = 0; c < 40; c++) begin
      tick();
      if (mem_req === 1'b1) acc++;
    end
    n_checks++;
    if (acc != 40 || mem_error !== 1'b0 || valid_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout got req_cycles=%0d err=%b valid=%b want 40 0 0",
               acc, mem_error, valid_OUT);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    n_checks++;
    if (valid_OUT !== 1'b1 || Read_Data_OUT !== 32'h0BAD_0BAD) begin
      n_fail++;
      $display("FAIL late_ack got valid=%b rd=%h want 1 0bad0bad", valid_OUT, Read_Data_OUT);
    end
`endif
    set_idle();
    tick();
  endtask

  task automatic test_random();
    localparam int N = 60;
    instr_t      prog[N];
    instr_t      cur;
    exp_t        exp_q[$];
    exp_t        e;
    int          idx = 0, cyc = 0, wait_cnt = 0, kind;
    logic        first = 1, s, exp_src = 0, exp_src_n;
    logic [31:0] exp_tgt = '0;
    for (int i = 0; i < N; i++) begin
      kind          = int'($urandom_range(3));
      prog[i].valid = ($urandom_range(4) != 0);
      prog[i].rd    = (kind == 1 || kind == 3);
      prog[i].wr    = (kind == 2 || kind == 3);
      prog[i].br    = ($urandom_range(2) == 0);
      prog[i].fl    = $urandom_range(1) == 1;
      prog[i].res   = $urandom;
      prog[i].op2   = $urandom;
      prog[i].jmp   = $urandom;
      prog[i].pc4   = $urandom;
      prog[i].rdata = $urandom;
      prog[i].lat   = int'($urandom_range(3));
    end
    cur = prog[0];
    while (cyc < 2000 && (idx < N || exp_q.size() != 0 || exp_src)) begin
      cyc++;
      if (valid_OUT === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious_valid cycle %0d got valid=1 want 0", cyc);
        end else begin
          e = exp_q.pop_front();
          if (Read_Data_OUT !== e.rdata || Result_ULA_Operator_OUT !== e.res ||
              Next_Instruct_OUT !== e.pc4) begin
            n_fail++;
            $display("FAIL rand_result cycle %0d got rd=%h res=%h pc4=%h want %h %h %h", cyc,
                     Read_Data_OUT, Result_ULA_Operator_OUT, Next_Instruct_OUT,
                     e.rdata, e.res, e.pc4);
          end
        end
      end
      n_checks++;
      if (PC_Src_OUT !== exp_src || (exp_src && Branch_Target_OUT !== exp_tgt)) begin
        n_fail++;
        $display("FAIL rand_branch cycle %0d got src=%b tgt=%h want %b %h", cyc,
                 PC_Src_OUT, Branch_Target_OUT, exp_src, exp_tgt);
      end
      exp_src_n = 0;
      if (idx < N) begin
        set_instr(cur.rd, cur.wr, cur.br, cur.fl, cur.res, cur.op2, cur.jmp, cur.pc4);
        valid_IN = cur.valid;
        if (first && cur.valid) begin
          exp_src_n = cur.br & cur.fl;
          if (exp_src_n) exp_tgt = cur.jmp;
          e.rdata = (cur.rd && !cur.wr) ? cur.rdata : 32'h0;
          e.res   = cur.res;
          e.pc4   = cur.pc4;
          exp_q.push_back(e);
        end
      end else begin
        set_idle();
      end
      exp_src = exp_src_n;
      if (mem_req === 1'b1) begin
        n_checks++;
        if (mem_addr !== (cur.res & 32'hFFFF_FFFC) || mem_we !== cur.wr ||
            mem_wdata !== cur.op2) begin
          n_fail++;
          $display("FAIL rand_access cycle %0d got addr=%h we=%b wd=%h want %h %b %h", cyc,
                   mem_addr, mem_we, mem_wdata, cur.res & 32'hFFFF_FFFC, cur.wr, cur.op2);
        end
        wait_cnt++;
        mem_ack   = (wait_cnt > cur.lat);
        mem_rdata = cur.rdata;
      end else begin
        mem_ack   = ($urandom_range(3) == 0);
        mem_rdata = $urandom;
      end
      #1 s = stall;
      tick();
      if (s === 1'b0 && idx < N) begin
        idx++;
        if (idx < N) cur = prog[idx];
        first    = 1;
        wait_cnt = 0;
      end else begin
        first = 0;
      end
    end
    n_checks++;
    if (idx != N || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain got issued=%0d pending=%0d want %0d 0", idx, exp_q.size(), N);
    end
    set_idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    tick();
    test_load();
    test_store();
    test_back_to_back();
    test_branch();
    test_clear_mid_access();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, maximum cycles the block waits for mem_ack (used only with MEM_TIMEOUT_EN).
REQ-002 clock  in  1  single clock; all state changes on posedge.
REQ-003 clear  in  1  reset, asynchronous, active-low.
REQ-004 valid_IN  in  1  EX/MEM register holds a live instruction.
REQ-005 Next_Instruct_IN, operator2_IN, Result_ULA_Jump_IN, Result_ULA_Operator_IN  in  32 each  EX/MEM outputs: PC+4, store data, branch target, ULA result/address.
REQ-006 Flag_ULA_IN, MemRead_IN, MemWrite_IN, Branch_IN  in  1 each  ULA zero flag and control bits.
REQ-007 mem_req, mem_we  out  1 each  data-memory request and write-enable.
REQ-008 mem_addr, mem_wdata  out  32 each  word-aligned address and store data.
REQ-009 mem_rdata  in  32; mem_ack  in  1  memory read data and one-cycle completion pulse.
REQ-010 stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM (drives their Write low).
REQ-011 PC_Src_OUT  out  1; Branch_Target_OUT  out  32  taken-branch redirect.
REQ-012 valid_OUT  out  1; Read_Data_OUT, Result_ULA_Operator_OUT, Next_Instruct_OUT  out  32 each  to MEM/WB register.
REQ-013 mem_error  out  1  access-timeout pulse.

Function
REQ-014 FSM states: IDLE, ACCESS, DONE.
REQ-015 IDLE, valid_IN=1 and MemRead_IN|MemWrite_IN: capture address, data, PC+4, result; next cycle ACCESS with mem_req=1.
REQ-016 mem_addr = {Result_ULA_Operator_IN[31:2], 2'b00}; mem_we = MemWrite_IN; MemRead_IN and MemWrite_IN both high -> write only.
REQ-017 ACCESS: mem_req, mem_addr, mem_we, mem_wdata held stable until mem_ack=1.
REQ-018 ACCESS with mem_ack=1: latch mem_rdata (read) or 0 (write) into Read_Data_OUT, mem_req=0 next cycle, go DONE.
REQ-019 DONE: valid_OUT=1 for exactly one cycle, then IDLE.
REQ-020 stall = 1 combinationally in IDLE when valid_IN and a memory op are present, in all of ACCESS, and 0 in DONE.
REQ-021 Non-memory valid instruction in IDLE: outputs registered, valid_OUT=1 next cycle, Read_Data_OUT=0, stall=0 (1-cycle latency, full throughput).
REQ-022 PC_Src_OUT = registered (valid_IN & Branch_IN & Flag_ULA_IN), one-cycle pulse; Branch_Target_OUT = registered Result_ULA_Jump_IN.
REQ-023 Branch evaluation occurs only on IDLE acceptance; a stalled instruction is never evaluated twice.
REQ-024 mem_ack outside ACCESS ignored; valid_IN=0 in IDLE -> valid_OUT=0 next cycle.

Reset
REQ-025 clear=0 forces state IDLE and all outputs to 0 (mem_req, mem_we, stall-registered terms, PC_Src_OUT, valid_OUT, mem_error, all 32-bit outputs) immediately, independent of clock.
REQ-026 clear asserted mid-ACCESS drops mem_req at once; the pending access is discarded with no valid_OUT.
REQ-027 After clear release, first accepted instruction is taken on the first posedge.

Configuration
REQ-028 Macro MEM_TIMEOUT_EN defined: counter counts ACCESS cycles; at TIMEOUT_CYCLES without mem_ack, mem_req=0, mem_error=1 for one cycle, Read_Data_OUT=0, go DONE.
REQ-029 MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; mem_error tied 0.
REQ-030 mem_ack in the same cycle the counter reaches TIMEOUT_CYCLES wins: normal completion, no mem_error.

Verification
REQ-031 Load addr 0x0000_0103, mem_ack after 3 cycles, rdata 0xDEAD_BEEF -> mem_addr 0x0000_0100, stall high 4 cycles, Read_Data_OUT 0xDEAD_BEEF with one valid_OUT pulse.
REQ-032 Store operator2 0x1234_5678 to 0x40, ack immediately -> mem_we=1, mem_wdata 0x1234_5678, Read_Data_OUT 0.
REQ-033 Back-to-back ALU ops result 5, 6, 7 -> valid_OUT high 3 consecutive cycles, stall never high.
REQ-034 Branch_IN=1, Flag_ULA_IN=1, target 0x80 -> PC_Src_OUT one pulse, Branch_Target_OUT 0x80; Flag_ULA_IN=0 -> no pulse.
REQ-035 clear low 2 cycles into a load -> mem_req, stall, valid_OUT 0 immediately; no valid_OUT for the aborted load.
REQ-036 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> mem_error pulse after 16 ACCESS cycles, Read_Data_OUT 0, back to IDLE.
